// File: rtl/l2_arb_pkg.sv
// Shared definitions for the L2 arbiter: FSM encoding, port ids and the
// default widths that the arbiter shares with the unified L2.
package l2_arb_pkg;

  localparam int L2_ADDR_W = 28;   // block address width seen by the L2
  localparam int L2_DATA_W = 128;  // one block = four 32-bit words
  localparam int L2_CNT_W  = 32;   // served-transaction counter width

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GNT_I = 2'd1,
    ST_GNT_D = 2'd2
  } state_e;

  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } port_e;

endpackage

// File: rtl/l2_arb_rr.sv
// Two-way round-robin pick: a lone requester wins outright, and on a tie the
// port that was not granted last time wins.
module l2_arb_rr
  import l2_arb_pkg::*;
(
  input  logic  req_i_i,
  input  logic  req_d_i,
  input  port_e last_grant_i,
  output port_e winner_o
);

  // Winner selection; meaningless (PORT_I) when nobody requests.
  always_comb begin
    winner_o = PORT_I;
    if (req_i_i && req_d_i) begin
      winner_o = (last_grant_i == PORT_I) ? PORT_D : PORT_I;
    end else if (req_d_i) begin
      winner_o = PORT_D;
    end
  end

endmodule

// File: rtl/l2_arbiter.sv
// Shares the unified L2 between the I-L1 and D-L1 miss interfaces.
// Handshake: a requester raises read or write (write wins if both) and holds
// it until its ready; the arbiter latches addr/wdata/op on the grant edge and
// drives the L2 only from those registers, so later requester changes are
// ignored. The L2 completes a transaction in any cycle where L2_ready=1 while
// a request is presented; that cycle is the one and only ready to the owner.
module l2_arbiter
  import l2_arb_pkg::*;
#(
  parameter int ADDR_W = L2_ADDR_W,
  parameter int DATA_W = L2_DATA_W,
  parameter int CNT_W  = L2_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_read,
  input  logic              i_write,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ready,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              L2_read,
  output logic              L2_write,
  output logic [ADDR_W-1:0] L2_addr,
  output logic [DATA_W-1:0] L2_wdata,
  input  logic [DATA_W-1:0] L2_rdata,
  input  logic              L2_ready,
  output logic [CNT_W-1:0]  i_served,
  output logic [CNT_W-1:0]  d_served,
  output state_e            state_o
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e             state_q, state_d;
  port_e              last_q, last_d;
  logic               op_wr_q, op_wr_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic [CNT_W-1:0]   i_served_q, i_served_d;
  logic [CNT_W-1:0]   d_served_q, d_served_d;

  logic  req_i, req_d;
  port_e winner;

  assign req_i = i_read | i_write;
  assign req_d = d_read | d_write;

  l2_arb_rr u_rr (
    .req_i_i      (req_i),
    .req_d_i      (req_d),
    .last_grant_i (last_q),
    .winner_o     (winner)
  );

  // The L2 only ever sees the latched address/data, so its hit logic never
  // sees an address change that is not backed by a request.
  assign L2_addr  = addr_q;
  assign L2_wdata = wdata_q;
  assign i_served = i_served_q;
  assign d_served = d_served_q;
  assign state_o  = state_q;

  // Next-state, request latching and per-port return path.
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    op_wr_d    = op_wr_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    i_served_d = i_served_q;
    d_served_d = d_served_q;
    L2_read    = 1'b0;
    L2_write   = 1'b0;
    i_ready    = 1'b0;
    d_ready    = 1'b0;
    i_rdata    = '0;
    d_rdata    = '0;
    case (state_q)
      ST_IDLE: begin
        if (req_i || req_d) begin
          if (winner == PORT_I) begin
            state_d = ST_GNT_I;
            op_wr_d = i_write;
            addr_d  = i_addr;
            wdata_d = i_wdata;
          end else begin
            state_d = ST_GNT_D;
            op_wr_d = d_write;
            addr_d  = d_addr;
            wdata_d = d_wdata;
          end
        end
      end
      ST_GNT_I: begin
        L2_read  = ~op_wr_q;
        L2_write = op_wr_q;
        i_ready  = L2_ready;
        if (!op_wr_q) i_rdata = L2_rdata;
        if (L2_ready) begin
          state_d = ST_IDLE;
          last_d  = PORT_I;
          if (i_served_q != '1) i_served_d = i_served_q + CNT_ONE;
        end
      end
      ST_GNT_D: begin
        L2_read  = ~op_wr_q;
        L2_write = op_wr_q;
        d_ready  = L2_ready;
        if (!op_wr_q) d_rdata = L2_rdata;
        if (L2_ready) begin
          state_d = ST_IDLE;
          last_d  = PORT_D;
          if (d_served_q != '1) d_served_d = d_served_q + CNT_ONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and request registers; reset aborts any transaction in flight and
  // leaves last grant at D so I wins the first tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      last_q     <= PORT_D;
      op_wr_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      i_served_q <= '0;
      d_served_q <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      op_wr_q    <= op_wr_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      i_served_q <= i_served_d;
      d_served_q <= d_served_d;
    end
  end

endmodule

// File: tb/tb_l2_arbiter.sv
// Directed bench for l2_arbiter: a vector table for single-grant behaviour,
// then hand-written sequences for fairness, long misses, address stability,
// counter saturation and asynchronous reset.
module tb_l2_arbiter;
  import l2_arb_pkg::*;

  localparam int AW = 28;
  localparam int DW = 128;
  localparam int CW = 4;

  logic          clk, reset;
  logic          i_read, i_write, d_read, d_write;
  logic [AW-1:0] i_addr, d_addr;
  logic [DW-1:0] i_wdata, d_wdata, i_rdata, d_rdata;
  logic          i_ready, d_ready;
  logic          L2_read, L2_write, L2_ready;
  logic [AW-1:0] L2_addr;
  logic [DW-1:0] L2_wdata, L2_rdata;
  logic [CW-1:0] i_served, d_served;
  state_e        state_o;

  int total = 0;
  int bad   = 0;
  int miss_len = 0;
  int busy_cnt;
  int exp_i_srv = 0;
  int exp_d_srv = 0;

  l2_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .i_read(i_read), .i_write(i_write), .i_addr(i_addr), .i_wdata(i_wdata),
    .i_rdata(i_rdata), .i_ready(i_ready),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .L2_read(L2_read), .L2_write(L2_write), .L2_addr(L2_addr),
    .L2_wdata(L2_wdata), .L2_rdata(L2_rdata), .L2_ready(L2_ready),
    .i_served(i_served), .d_served(d_served), .state_o(state_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // L2 stand-in: read data is a pattern of the address; completes after
  // miss_len stall cycles of a continuously presented request.
  function automatic logic [DW-1:0] rd_pat(input logic [AW-1:0] a);
    return {4{4'hA, a}};
  endfunction

  assign L2_rdata = rd_pat(L2_addr);
  assign L2_ready = (L2_read | L2_write) && (busy_cnt >= miss_len);

  always @(posedge clk or posedge reset) begin
    if (reset) busy_cnt <= 0;
    else if ((L2_read | L2_write) && !L2_ready) busy_cnt <= busy_cnt + 1;
    else busy_cnt <= 0;
  end

  // scoreboard helpers
  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drop_all();
    i_read = 0; i_write = 0; d_read = 0; d_write = 0;
  endtask

  function automatic int sat(input int x);
    return (x < (1 << CW) - 1) ? x + 1 : x;
  endfunction

  task automatic chk_counts(input string nm);
    chk({nm, "_i_served"}, DW'(i_served), DW'(exp_i_srv));
    chk({nm, "_d_served"}, DW'(d_served), DW'(exp_d_srv));
  endtask

  typedef struct {
    logic          ir, iw;
    logic [AW-1:0] ia;
    logic          dr, dw;
    logic [AW-1:0] da;
    logic [1:0]    gnt;    // 0 none, 1 I, 2 D
    logic          ewr;
    logic [AW-1:0] eaddr;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [DW-1:0] exp_wd, dead_beef;
    logic [AW-1:0] lat_addr;
    int pulses;
    state_e exp_st;

    reset = 1'b1;
    drop_all();
    i_addr = '0; d_addr = '0; i_wdata = '0; d_wdata = '0;
    #12;
    chk("rst_state", DW'(state_o), DW'(ST_IDLE));
    chk("rst_l2_rw", DW'({L2_read, L2_write}), '0);
    chk("rst_l2_addr", DW'(L2_addr), '0);
    chk("rst_l2_wdata", L2_wdata, '0);
    chk("rst_ready", DW'({i_ready, d_ready}), '0);
    chk("rst_rdata", i_rdata | d_rdata, '0);
    chk_counts("rst");
    @(negedge clk);
    reset = 1'b0;

    // ---------------- table of single grants (all L2 hits) ---------------
    //            ir iw ia            dr dw da            gnt ewr eaddr
    vecs[0] = '{1, 0, 28'h0000010, 0, 0, 28'h0,       1, 0, 28'h0000010};
    vecs[1] = '{0, 0, 28'h0,       1, 0, 28'h0000020, 2, 0, 28'h0000020};
    vecs[2] = '{1, 0, 28'h0000030, 0, 1, 28'h0000040, 1, 0, 28'h0000030};
    vecs[3] = '{1, 0, 28'h0000050, 0, 1, 28'h0000060, 2, 1, 28'h0000060};
    vecs[4] = '{0, 0, 28'h0,       1, 1, 28'h0000070, 2, 1, 28'h0000070};
    vecs[5] = '{0, 1, 28'h0000080, 1, 0, 28'h0000090, 1, 1, 28'h0000080};
    vecs[6] = '{0, 0, 28'h0,       0, 0, 28'h0,       0, 0, 28'h0000080};
    vecs[7] = '{1, 0, 28'h00000A0, 1, 0, 28'h00000B0, 2, 0, 28'h00000B0};

    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      miss_len = 0;
      i_read = vecs[k].ir; i_write = vecs[k].iw; i_addr = vecs[k].ia;
      d_read = vecs[k].dr; d_write = vecs[k].dw; d_addr = vecs[k].da;
      i_wdata = {4{32'h1000_0000 + k}};
      d_wdata = {4{32'h2000_0000 + k}};
      tick();
      exp_st = (vecs[k].gnt == 2'd1) ? ST_GNT_I : (vecs[k].gnt == 2'd2) ? ST_GNT_D : ST_IDLE;
      chk($sformatf("v%0d_state", k), DW'(state_o), DW'(exp_st));
      chk($sformatf("v%0d_l2_read", k), DW'(L2_read), DW'(vecs[k].gnt != 0 && !vecs[k].ewr));
      chk($sformatf("v%0d_l2_write", k), DW'(L2_write), DW'(vecs[k].gnt != 0 && vecs[k].ewr));
      chk($sformatf("v%0d_l2_addr", k), DW'(L2_addr), DW'(vecs[k].eaddr));
      chk($sformatf("v%0d_i_ready", k), DW'(i_ready), DW'(vecs[k].gnt == 2'd1));
      chk($sformatf("v%0d_d_ready", k), DW'(d_ready), DW'(vecs[k].gnt == 2'd2));
      chk($sformatf("v%0d_i_rdata", k), i_rdata,
          (vecs[k].gnt == 2'd1 && !vecs[k].ewr) ? rd_pat(vecs[k].eaddr) : '0);
      chk($sformatf("v%0d_d_rdata", k), d_rdata,
          (vecs[k].gnt == 2'd2 && !vecs[k].ewr) ? rd_pat(vecs[k].eaddr) : '0);
      if (vecs[k].ewr) begin
        exp_wd = (vecs[k].gnt == 2'd1) ? {4{32'h1000_0000 + k}} : {4{32'h2000_0000 + k}};
        chk($sformatf("v%0d_l2_wdata", k), L2_wdata, exp_wd);
      end
      if (vecs[k].gnt == 2'd1) exp_i_srv = sat(exp_i_srv);
      if (vecs[k].gnt == 2'd2) exp_d_srv = sat(exp_d_srv);
      @(negedge clk);
      drop_all();
      tick();
      chk($sformatf("v%0d_back_idle", k), DW'(state_o), DW'(ST_IDLE));
      chk($sformatf("v%0d_idle_rw", k), DW'({L2_read, L2_write}), '0);
      chk_counts($sformatf("v%0d", k));
    end

    // ---------------- fairness: both read continuously --------------------
    @(negedge clk);
    miss_len = 0;
    i_read = 1; i_addr = 28'h0000200;
    d_read = 1; d_addr = 28'h0000300;
    for (int c = 0; c < 16; c++) begin
      tick();
      exp_st = (c % 4 == 0) ? ST_GNT_I : (c % 4 == 2) ? ST_GNT_D : ST_IDLE;
      chk($sformatf("rr_c%0d_state", c), DW'(state_o), DW'(exp_st));
      chk($sformatf("rr_c%0d_both_ready", c), DW'(i_ready & d_ready), '0);
      chk($sformatf("rr_c%0d_i_ready", c), DW'(i_ready), DW'(exp_st == ST_GNT_I));
      chk($sformatf("rr_c%0d_d_ready", c), DW'(d_ready), DW'(exp_st == ST_GNT_D));
      if (exp_st == ST_GNT_I) exp_i_srv = sat(exp_i_srv);
      if (exp_st == ST_GNT_D) exp_d_srv = sat(exp_d_srv);
    end
    @(negedge clk);
    drop_all();
    tick();
    chk_counts("rr");

    // ---------------- D write with a 20-cycle miss, I waiting -------------
    dead_beef = 128'hDEAD_0000_1111_2222_3333_4444_5555_BEEF;
    @(negedge clk);
    miss_len = 20;
    d_write = 1; d_addr = 28'h00000A3; d_wdata = dead_beef;
    tick();
    chk("dw_state", DW'(state_o), DW'(ST_GNT_D));
    pulses = 0;
    for (int c = 0; c <= 20; c++) begin
      if (c > 0) tick();
      chk($sformatf("dw_c%0d_write", c), DW'({L2_write, L2_read}), DW'(2'b10));
      chk($sformatf("dw_c%0d_addr", c), DW'(L2_addr), DW'(28'h00000A3));
      chk($sformatf("dw_c%0d_wdata", c), L2_wdata, dead_beef);
      chk($sformatf("dw_c%0d_i_ready", c), DW'(i_ready), '0);
      chk($sformatf("dw_c%0d_d_ready", c), DW'(d_ready), DW'(c == 20));
      if (d_ready) pulses++;
      @(negedge clk);
      i_read = 1; i_addr = 28'h0000400 + 28'(c);
      d_wdata = ~dead_beef;
      d_addr = 28'h0000555;
    end
    chk("dw_ready_pulses", DW'(pulses), DW'(1));
    exp_d_srv = sat(exp_d_srv);
    d_write = 0;
    miss_len = 5;
    tick();
    chk("dw_turn_state", DW'(state_o), DW'(ST_IDLE));
    chk("dw_turn_addr", DW'(L2_addr), DW'(28'h00000A3));
    chk("dw_turn_rw", DW'({L2_read, L2_write}), '0);
    chk("dw_turn_i_ready", DW'(i_ready), '0);
    chk_counts("dw");

    // ---------------- I read miss while the requester moves its address ---
    lat_addr = i_addr;
    tick();
    chk("ir_state", DW'(state_o), DW'(ST_GNT_I));
    for (int c = 0; c <= 5; c++) begin
      if (c > 0) tick();
      chk($sformatf("ir_c%0d_addr", c), DW'(L2_addr), DW'(lat_addr));
      chk($sformatf("ir_c%0d_read", c), DW'({L2_read, L2_write}), DW'(2'b10));
      chk($sformatf("ir_c%0d_i_ready", c), DW'(i_ready), DW'(c == 5));
      @(negedge clk);
      i_addr = 28'h0000700 + 28'(c);
    end
    exp_i_srv = sat(exp_i_srv);
    drop_all();
    tick();
    chk("ir_idle_addr", DW'(L2_addr), DW'(lat_addr));
    chk("ir_idle_rw", DW'({L2_read, L2_write}), '0);
    chk_counts("ir");

    // ---------------- saturation of i_served ------------------------------
    miss_len = 0;
    for (int n = 0; n < 16; n++) begin
      @(negedge clk);
      i_read = 1; i_addr = 28'h0000800 + 28'(n);
      tick();
      exp_i_srv = sat(exp_i_srv);
      @(negedge clk);
      drop_all();
      tick();
      chk_counts($sformatf("sat%0d", n));
    end
    chk("sat_all_ones", DW'(i_served), DW'({CW{1'b1}}));

    // ---------------- async reset in the middle of a D miss ---------------
    @(negedge clk);
    miss_len = 50;
    d_read = 1; d_addr = 28'h0000C00;
    tick();
    chk("ar_state_pre", DW'(state_o), DW'(ST_GNT_D));
    tick();
    tick();
    #2;
    reset = 1'b1;
    #1;
    chk("ar_state", DW'(state_o), DW'(ST_IDLE));
    chk("ar_l2_rw", DW'({L2_read, L2_write}), '0);
    chk("ar_l2_addr", DW'(L2_addr), '0);
    chk("ar_l2_wdata", L2_wdata, '0);
    chk("ar_ready", DW'({i_ready, d_ready}), '0);
    chk("ar_rdata", i_rdata | d_rdata, '0);
    exp_i_srv = 0;
    exp_d_srv = 0;
    chk_counts("ar");
    @(negedge clk);
    reset = 1'b0;
    miss_len = 0;
    i_read = 1; i_addr = 28'h0000D00;
    tick();
    chk("ar_tie_state", DW'(state_o), DW'(ST_GNT_I));
    chk("ar_tie_addr", DW'(L2_addr), DW'(28'h0000D00));
    exp_i_srv = sat(exp_i_srv);
    @(negedge clk);
    drop_all();
    tick();
    chk_counts("ar_after");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: sim time %0t exceeded limit", $time);
    $fatal(1);
  end

endmodule
